// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes, mux/ALU codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    // FSM state encodings; 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp: add, subtract (compare), or let alu_control decode funct
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB: register B, constant 4, sign-extended imm, shifted imm
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PCSource: ALU result, ALUOut register, jump target
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True when DECODE knows where to send this opcode
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath; outputs decode registered state (+mem_ready in FETCH).
// Latency: 3-5 cycles per instruction with mem_ready high; state advances on each rising clk edge.
// Backpressure: mem_ready=0 holds FETCH/MEM_READ/MEM_WRITE one extra cycle per low cycle.
module multicycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    logic   illegal_d;

    // Next-state selection; anything unrecognised falls back to FETCH
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_op;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OPcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default:      state_d = S_FETCH;
                endcase
                if (!op_supported(OPcode)) begin
                    illegal_d = 1'b1;
                end
            end
            // LW/SW split is judged on the opcode present in this cycle
            S_MEM_ADDR: begin
                if (OPcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (OPcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_MEM_WB:    state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // State and sticky illegal-opcode flag; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            illegal_op <= illegal_d;
        end
    end

    assign state = state_q;

    // Control decode per state; reset gates everything low so no write strobe survives it
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BRANCH;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with an instruction-level expectation queue.
// Latency: one expectation per clock cycle, checked on the falling edge.
// Backpressure: mem_ready stalls are scripted per instruction.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] OPcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       illegal_op;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    logic [15:0] dut_ctrl;
    assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                       IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    // Control table per state, straight from the datapath control chart
    logic [15:0] tbl [0:15];
    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = 16'h0000;
        tbl[0]  = {10'b0001000000, 2'b01, 2'b00, 2'b00}; // FETCH (PCWrite/IRWrite added from mem_ready)
        tbl[1]  = {10'b0000000000, 2'b11, 2'b00, 2'b00}; // DECODE
        tbl[2]  = {10'b0000000001, 2'b10, 2'b00, 2'b00}; // MEM_ADDR
        tbl[3]  = {10'b0011000000, 2'b00, 2'b00, 2'b00}; // MEM_READ
        tbl[4]  = {10'b0000010010, 2'b00, 2'b00, 2'b00}; // MEM_WB
        tbl[5]  = {10'b0010100000, 2'b00, 2'b00, 2'b00}; // MEM_WRITE
        tbl[6]  = {10'b0000000001, 2'b00, 2'b10, 2'b00}; // R_EXEC
        tbl[7]  = {10'b0000000110, 2'b00, 2'b00, 2'b00}; // R_WB
        tbl[8]  = {10'b0100000001, 2'b00, 2'b01, 2'b01}; // BRANCH
        tbl[9]  = {10'b1000000000, 2'b00, 2'b00, 2'b10}; // JUMP
        tbl[10] = {10'b0000000001, 2'b10, 2'b00, 2'b00}; // I_EXEC
        tbl[11] = {10'b0000000010, 2'b00, 2'b00, 2'b00}; // I_WB
    end

    function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
        logic [15:0] v;
        v = tbl[s];
        if (s == 4'd0) begin
            v[15] = mr;
            v[9]  = mr;
        end
        return v;
    endfunction

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncyc  = 0;
    int   rw_hits = 0;
    logic ill_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Single compare process: one queued expectation per clock cycle
    always @(negedge clk) begin
        if (RegWrite === 1'b1) rw_hits++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state", {28'd0, state}, {28'd0, e.st});
            chk("controls", {16'd0, dut_ctrl}, {16'd0, exp_ctrl(e.st, e.mr)});
            chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
        end
    end

    // One clock cycle: apply inputs, queue the state/flag this cycle must show
    task automatic cycle(input logic [5:0] op, input logic mr, input logic [3:0] st);
        OPcode    = op;
        mem_ready = mr;
        exp_q.push_back('{st: st, mr: mr, ill: ill_m});
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: the state walk each opcode must take
    task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                             input int mw, input int lit_cycles);
        logic rb;
        ncyc = 0;
        for (int i = 0; i < fw; i++) cycle(op, 1'b0, 4'd0);
        cycle(op, 1'b1, 4'd0);
        rb = 1'($urandom_range(0, 1));
        cycle(op, rb, 4'd1);
        case (op)
            6'b000000: begin cycle(op, rb, 4'd6); cycle(op, ~rb, 4'd7); end
            6'b001000: begin cycle(op, ~rb, 4'd10); cycle(op, rb, 4'd11); end
            6'b100011: begin
                cycle(op, rb, 4'd2);
                for (int i = 0; i < mw; i++) cycle(op, 1'b0, 4'd3);
                cycle(op, 1'b1, 4'd3);
                cycle(op, rb, 4'd4);
            end
            6'b101011: begin
                cycle(op, rb, 4'd2);
                for (int i = 0; i < mw; i++) cycle(op, 1'b0, 4'd5);
                cycle(op, 1'b1, 4'd5);
            end
            6'b000100: cycle(op, rb, 4'd8);
            6'b000010: cycle(op, rb, 4'd9);
            default:   ill_m = 1'b1;
        endcase
        chk({name, "_cycles"}, ncyc, lit_cycles);
        chk({name, "_back_to_fetch"}, {28'd0, state}, 32'd0);
    endtask

    initial begin
        int rw_before;
        rst_n = 1'b0;
        OPcode = 6'b000000;
        mem_ready = 1'b1;
        #2;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_ctrl_zero", {16'd0, dut_ctrl}, 32'd0);
        chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold_state", {28'd0, state}, 32'd0);
        #1 rst_n = 1'b1;

        run_instr("r_type", 6'b000000, 0, 0, 4);
        run_instr("r_fetch_wait", 6'b000000, 1, 0, 5);
        run_instr("addi", 6'b001000, 0, 0, 4);
        run_instr("lw_wait2", 6'b100011, 0, 2, 7);
        rw_before = rw_hits;
        run_instr("sw", 6'b101011, 0, 0, 4);
        run_instr("sw_wait1", 6'b101011, 0, 1, 5);
        chk("sw_no_regwrite", rw_hits - rw_before, 32'd0);
        run_instr("beq", 6'b000100, 0, 0, 3);
        run_instr("j", 6'b000010, 0, 0, 3);
        run_instr("illegal", 6'b111111, 0, 0, 2);
        chk("illegal_set", {31'd0, illegal_op}, 32'd1);
        run_instr("r_after_illegal", 6'b000000, 0, 0, 4);
        chk("illegal_sticky", {31'd0, illegal_op}, 32'd1);

        // Reset dropped mid-cycle while in MEM_WB
        ncyc = 0;
        cycle(6'b100011, 1'b1, 4'd0);
        cycle(6'b100011, 1'b1, 4'd1);
        cycle(6'b100011, 1'b1, 4'd2);
        cycle(6'b100011, 1'b1, 4'd3);
        chk("pre_reset_in_mem_wb", {28'd0, state}, 32'd4);
        #2;
        rw_before = rw_hits;
        rst_n = 1'b0;
        ill_m = 1'b0;
        #1;
        chk("midreset_state", {28'd0, state}, 32'd0);
        chk("midreset_ctrl_zero", {16'd0, dut_ctrl}, 32'd0);
        chk("midreset_illegal_clr", {31'd0, illegal_op}, 32'd0);
        @(posedge clk);
        #1;
        chk("midreset_no_regwrite", rw_hits - rw_before, 32'd0);
        chk("midreset_hold_ctrl", {16'd0, dut_ctrl}, 32'd0);
        #2 rst_n = 1'b1;
        run_instr("r_after_reset", 6'b000000, 0, 0, 4);

        @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have ports clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 The block SHALL have port OPcode (input, 6, opcode from the instruction register stage).
REQ-003 The block SHALL have port mem_ready (input, 1, memory completes the current access this cycle).
REQ-004 The block SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite and ALUSrcA (each output, 1, datapath controls).
REQ-005 The block SHALL have ports ALUSrcB, ALUOp and PCSource (each output, 2, datapath mux and ALU controls).
REQ-006 The block SHALL have ports state (output, 4, current FSM state) and illegal_op (output, 1, unsupported opcode latched).

Function
REQ-007 The block SHALL be a Moore FSM; every control output SHALL be a combinational decode of the registered state plus mem_ready, as listed below.
REQ-008 The FSM SHALL have the states and encodings FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10 and I_WB=11; encodings 12-15 are unused.
REQ-009 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00, with IRWrite=PCWrite=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-010 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00, and SHALL branch on OPcode as follows.
  - 000000 -> R_EXEC
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR
  - 000100 (BEQ) -> BRANCH
  - 000010 (J) -> JUMP
  - 001000 (ADDI) -> I_EXEC
  - any other value -> FETCH, with illegal_op set
REQ-011 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, and SHALL go to MEM_READ for LW or MEM_WRITE for SW, judged on the OPcode held in this cycle.
REQ-012 MEM_READ SHALL drive MemRead=1 and IorD=1, and SHALL wait for mem_ready=1 before going to MEM_WB.
REQ-013 MEM_WRITE SHALL drive MemWrite=1 and IorD=1, and SHALL wait for mem_ready=1 before going to FETCH.
REQ-014 MEM_WB SHALL drive RegWrite=1, MemtoReg=1 and RegDst=0, and SHALL go to FETCH.
REQ-015 R_EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10, and SHALL go to R_WB.
REQ-016 R_WB SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0, and SHALL go to FETCH.
REQ-017 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01, and SHALL go to FETCH.
REQ-018 JUMP SHALL drive PCWrite=1 and PCSource=10, and SHALL go to FETCH.
REQ-019 I_EXEC SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, and SHALL go to I_WB.
REQ-020 I_WB SHALL drive RegWrite=1, RegDst=0 and MemtoReg=0, and SHALL go to FETCH.
REQ-021 Any control output not listed for a state SHALL be 0 in that state.
REQ-022 An unused state encoding SHALL drive all controls to 0 and SHALL go to FETCH on the next edge.
REQ-023 illegal_op SHALL be sticky: it SHALL be set on the edge leaving DECODE with an unsupported opcode and cleared only by reset.
REQ-024 Cycle counts from entry to FETCH with mem_ready held at 1 SHALL be: R=4, ADDI=4, LW=5, SW=4, BEQ=3, J=3; each extra mem_ready=0 cycle in a memory state SHALL add exactly one cycle.

Reset
REQ-025 While rst_n=0, state SHALL be FETCH and illegal_op SHALL be 0, immediately and independent of clk.
REQ-026 While rst_n=0, all control outputs SHALL be forced to 0, including the FETCH MemRead.
REQ-027 An assertion of rst_n mid-instruction SHALL abandon the instruction with no further RegWrite, MemWrite or PCWrite.
REQ-028 On the first clk edge after rst_n rises, the FSM SHALL evaluate FETCH normally.

Structure
REQ-029 The state encodings, the six opcode constants, and the ALUOp/ALUSrcB/PCSource codes SHALL live in a shared package cpu_ctrl_pkg, for reuse by the datapath and ALU control.
REQ-030 The block SHALL be a single module with no sub-modules; the ALU-function decode belongs to the separate block alu_control.

Verification
REQ-031 The bench SHALL cover reset then mem_ready=1 and OPcode=000000 -> states 0,1,6,7,0, with RegWrite=1 and RegDst=1 only in state 7.
REQ-032 The bench SHALL cover LW (100011) with mem_ready low for 2 cycles in MEM_READ -> state 3 held 3 cycles and a 7-cycle instruction, with MemtoReg=1 only in state 4.
REQ-033 The bench SHALL cover SW (101011) -> MemWrite=1 only in state 5, IorD=1, and RegWrite never asserted.
REQ-034 The bench SHALL cover BEQ (000100) then J (000010) -> PCWriteCond=1 with PCSource=01 in state 8, then PCWrite=1 with PCSource=10 in state 9.
REQ-035 The bench SHALL cover OPcode=111111 -> DECODE returns to FETCH, illegal_op=1 and stays 1 across a following R instruction.
REQ-036 The bench SHALL cover rst_n dropped mid-cycle in state 4 -> state=0 and all controls 0 before the next clk edge, and no RegWrite pulse.
